// File: rtl/cyx_vram_pkg.sv
// Shared definitions for the VRAM arbiter slice: FSM state encoding, port IDs
// and default geometry of the shared data RAM.
package cyx_vram_pkg;

  localparam int unsigned DEFAULT_DEPTH  = 16;
  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_ADDR_W = 32;

  // Port identifiers; also the encoding of the owner and last-winner bits.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/cyx_vram_arbiter_if.sv
// Bus bundle between the two requesters (A = CPU data side, B = host/debug
// loader), the arbiter and the RAM.
//   slave  : arbiter view (requests and ram_dout in; grants, completions,
//            read data and RAM controls out)
//   master : requester/RAM view (the reverse)
interface cyx_vram_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) ();

  logic              a_req,   b_req;
  logic              a_we,    b_we;
  logic [ADDR_W-1:0] a_addr,  b_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata;
  logic              a_gnt,   b_gnt;
  logic              a_done,  b_done;
  logic              a_err,   b_err;
  logic [DATA_W-1:0] a_rdata, b_rdata;

  logic [DATA_W-1:0] ram_din;
  logic [ADDR_W-1:0] ram_adr;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, ram_dout,
    output a_gnt, a_done, a_err, a_rdata, b_gnt, b_done, b_err, b_rdata,
    output ram_din, ram_adr, ram_wren
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, ram_dout,
    input  a_gnt, a_done, a_err, a_rdata, b_gnt, b_done, b_err, b_rdata,
    input  ram_din, ram_adr, ram_wren
  );

endinterface

// File: rtl/cyx_rr_arb2.sv
// Two-way request picker.
//   req[1:0] : request vector, bit PORT_A / PORT_B
//   last     : port that won the previous tie
//   en       : picker is being consulted (arbiter in IDLE)
//   winner   : chosen port (PORT_A / PORT_B), meaningful when |req
//   update   : load winner into the last pointer
// Build option: CYX_VRAM_ARB_FIXED_PRIO_EN makes A win every tie and leaves
// the last pointer unused.
module cyx_rr_arb2
  import cyx_vram_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic       winner,
  output logic       update
);

`ifdef CYX_VRAM_ARB_FIXED_PRIO_EN
  logic unused_rr;
  assign unused_rr = last ^ en;

  always_comb begin
    winner = req[PORT_A] ? PORT_A : PORT_B;
    update = 1'b0;
  end
`else
  logic both;
  assign both = req[PORT_A] & req[PORT_B];

  always_comb begin
    winner = PORT_A;
    update = 1'b0;
    if (both) begin
      // The port that did not win the last tie goes first.
      winner = ~last;
      update = en;
    end else if (req[PORT_B]) begin
      winner = PORT_B;
    end
  end
`endif

endmodule

// File: rtl/cyx_vram_arbiter.sv
// Arbiter sharing the single data RAM between port A (CPU) and port B
// (host/debug loader). Each access runs IDLE -> GNT -> RESP; misaligned or
// out-of-range accesses are suppressed and reported with err alongside done.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : cyx_vram_arbiter_if.slave (requester handshakes + RAM side)
// Build option: CYX_VRAM_ARB_FIXED_PRIO_EN (fixed A priority in cyx_rr_arb2).
module cyx_vram_arbiter
  import cyx_vram_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH
) (
  input logic                clk,
  input logic                rst_n,
  cyx_vram_arbiter_if.slave  bus
);

  localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(4 * DEPTH);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              winner, update;
  logic              in_gnt;
  logic              owner_we, legal;
  logic [ADDR_W-1:0] owner_addr;
  logic [DATA_W-1:0] owner_wdata;

  logic              a_gnt_q, b_gnt_q, a_done_q, b_done_q, a_err_q, b_err_q;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

  cyx_rr_arb2 u_pick (
    .req    ({bus.b_req, bus.a_req}),
    .last   (last_q),
    .en     (state_q == ST_IDLE),
    .winner (winner),
    .update (update)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.a_req || bus.b_req) begin
          state_d = ST_GNT;
          owner_d = winner;
          if (update) last_d = winner;
        end
      end
      ST_GNT:  state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_gnt      = (state_q == ST_GNT);
  assign owner_we    = (owner_q == PORT_A) ? bus.a_we    : bus.b_we;
  assign owner_addr  = (owner_q == PORT_A) ? bus.a_addr  : bus.b_addr;
  assign owner_wdata = (owner_q == PORT_A) ? bus.a_wdata : bus.b_wdata;
  assign legal       = (owner_addr[1:0] == 2'b00) && (owner_addr < ADDR_END);

  // The RAM only sees a non-zero bus while an access is granted.
  assign bus.ram_wren = in_gnt & owner_we & legal;
  assign bus.ram_adr  = in_gnt ? owner_addr  : '0;
  assign bus.ram_din  = in_gnt ? owner_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= PORT_A;
      last_q    <= PORT_B;
      a_gnt_q   <= 1'b0;
      b_gnt_q   <= 1'b0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      a_err_q   <= 1'b0;
      b_err_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      a_gnt_q  <= (state_d == ST_GNT) && (owner_d == PORT_A);
      b_gnt_q  <= (state_d == ST_GNT) && (owner_d == PORT_B);
      // done/err are registered at the GNT closing edge so they land in RESP.
      a_done_q <= in_gnt && (owner_q == PORT_A);
      b_done_q <= in_gnt && (owner_q == PORT_B);
      a_err_q  <= in_gnt && (owner_q == PORT_A) && !legal;
      b_err_q  <= in_gnt && (owner_q == PORT_B) && !legal;
      if (in_gnt && legal && !owner_we) begin
        if (owner_q == PORT_A) a_rdata_q <= bus.ram_dout;
        else                   b_rdata_q <= bus.ram_dout;
      end
    end
  end

  assign bus.a_gnt   = a_gnt_q;
  assign bus.b_gnt   = b_gnt_q;
  assign bus.a_done  = a_done_q;
  assign bus.b_done  = b_done_q;
  assign bus.a_err   = a_err_q;
  assign bus.b_err   = b_err_q;
  assign bus.a_rdata = a_rdata_q;
  assign bus.b_rdata = b_rdata_q;

endmodule

// File: tb/tb_cyx_vram_arbiter.sv
// Directed bench for cyx_vram_arbiter with a 16-word behavioural RAM.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_cyx_vram_arbiter;

  logic clk;
  logic rst_n;
  logic mem_init;
  logic [31:0] mem [16];

  int n_vec;
  int n_bad;

  cyx_vram_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  cyx_vram_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: combinational read, synchronous write.
  assign bus.ram_dout = mem[bus.ram_adr[5:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA500_0000 | i;
    end else if (bus.ram_wren) begin
      mem[bus.ram_adr[5:2]] <= bus.ram_din;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_b;
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    mem_init = 1'b1;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    tick();
    tick();

    // Reset state
    chk("rst_a_gnt",   bus.a_gnt,    0);
    chk("rst_b_gnt",   bus.b_gnt,    0);
    chk("rst_a_done",  bus.a_done,   0);
    chk("rst_b_done",  bus.b_done,   0);
    chk("rst_a_err",   bus.a_err,    0);
    chk("rst_b_err",   bus.b_err,    0);
    chk("rst_a_rdata", bus.a_rdata,  0);
    chk("rst_b_rdata", bus.b_rdata,  0);
    chk("rst_wren",    bus.ram_wren, 0);
    chk("rst_adr",     bus.ram_adr,  0);
    rst_n = 1'b1;
    mem_init = 1'b0;

    // A write 0xDEADBEEF to 0x8
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 32'h8; bus.a_wdata = 32'hDEAD_BEEF;
    chk("wr_c0_gnt", bus.a_gnt, 0);
    chk("wr_c0_wren", bus.ram_wren, 0);
    tick();
    chk("wr_c1_a_gnt", bus.a_gnt,    1);
    chk("wr_c1_b_gnt", bus.b_gnt,    0);
    chk("wr_c1_wren",  bus.ram_wren, 1);
    chk("wr_c1_adr",   bus.ram_adr,  32'h8);
    chk("wr_c1_din",   bus.ram_din,  32'hDEAD_BEEF);
    tick();
    chk("wr_c2_gnt",  bus.a_gnt,  0);
    chk("wr_c2_done", bus.a_done, 1);
    chk("wr_c2_err",  bus.a_err,  0);
    chk("wr_c2_wren", bus.ram_wren, 0);
    bus.a_req = 1'b0;
    tick();
    chk("wr_c3_done", bus.a_done, 0);

    // A read back 0x8
    bus.a_req = 1'b1; bus.a_we = 1'b0;
    tick();
    chk("rd_c1_gnt",  bus.a_gnt,    1);
    chk("rd_c1_wren", bus.ram_wren, 0);
    chk("rd_c1_adr",  bus.ram_adr,  32'h8);
    tick();
    chk("rd_c2_done",  bus.a_done,   1);
    chk("rd_c2_err",   bus.a_err,    0);
    chk("rd_c2_rdata", bus.a_rdata,  32'hDEAD_BEEF);
    chk("rd_c2_wren",  bus.ram_wren, 0);
    bus.a_req = 1'b0;
    tick();

    // B legal read of 0xC, giving b_rdata a known value
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 32'hC;
    tick();
    chk("brd_c1_gnt", bus.b_gnt, 1);
    tick();
    chk("brd_c2_done",  bus.b_done,  1);
    chk("brd_c2_err",   bus.b_err,   0);
    chk("brd_c2_rdata", bus.b_rdata, 32'hA500_0003);
    tick();

    // B misaligned write to 0x6
    bus.b_we = 1'b1; bus.b_addr = 32'h6; bus.b_wdata = 32'h1234_5678;
    tick();
    chk("mis_c1_gnt",  bus.b_gnt,    1);
    chk("mis_c1_wren", bus.ram_wren, 0);
    chk("mis_c1_adr",  bus.ram_adr,  32'h6);
    tick();
    chk("mis_c2_done",  bus.b_done,  1);
    chk("mis_c2_err",   bus.b_err,   1);
    chk("mis_c2_rdata", bus.b_rdata, 32'hA500_0003);
    tick();
    chk("mis_c3_err", bus.b_err, 0);

    // B out-of-range write to 0x40
    bus.b_addr = 32'h40;
    tick();
    chk("oor_c1_gnt",  bus.b_gnt,    1);
    chk("oor_c1_wren", bus.ram_wren, 0);
    tick();
    chk("oor_c2_done",  bus.b_done,  1);
    chk("oor_c2_err",   bus.b_err,   1);
    chk("oor_c2_rdata", bus.b_rdata, 32'hA500_0003);
    bus.b_req = 1'b0;
    tick();

    // RAM words 1 and 0 untouched by the suppressed writes
    chk("mem1_kept", mem[1], 32'hA500_0001);
    chk("mem0_kept", mem[0], 32'hA500_0000);

    // Contention right after reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 32'h0;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 32'hC;
    for (int k = 0; k < 4; k++) begin
`ifdef CYX_VRAM_ARB_FIXED_PRIO_EN
      exp_b = 1'b0;
`else
      exp_b = (k % 2) == 1;
`endif
      tick();
      chk("con_a_gnt", bus.a_gnt, {31'd0, !exp_b});
      chk("con_b_gnt", bus.b_gnt, {31'd0, exp_b});
      tick();
      chk("con_a_done", bus.a_done, {31'd0, !exp_b});
      chk("con_b_done", bus.b_done, {31'd0, exp_b});
      if (exp_b) chk("con_b_rdata", bus.b_rdata, 32'hA500_0003);
      else       chk("con_a_rdata", bus.a_rdata, 32'hA500_0000);
      tick();
      chk("con_idle_a_gnt", bus.a_gnt, 0);
      chk("con_idle_b_gnt", bus.b_gnt, 0);
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    tick();

    // Reset asserted during A's GNT cycle
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 32'h10; bus.a_wdata = 32'h0000_0055;
    tick();
    chk("mrst_pre_gnt", bus.a_gnt, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_a_gnt",   bus.a_gnt,   0);
    chk("mrst_a_done",  bus.a_done,  0);
    chk("mrst_a_rdata", bus.a_rdata, 0);
    chk("mrst_wren",    bus.ram_wren, 0);
    tick();
    rst_n = 1'b1;
    bus.a_we = 1'b0; bus.a_addr = 32'h8;
    tick();
    chk("mrst_new_gnt", bus.a_gnt, 1);
    tick();
    chk("mrst_new_done",  bus.a_done,  1);
    chk("mrst_new_rdata", bus.a_rdata, 32'hDEAD_BEEF);
    bus.a_req = 1'b0;
    tick();

    // Request dropped during GNT of a read at 0x4
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 32'h4;
    tick();
    chk("drop_gnt", bus.a_gnt, 1);
    bus.a_req = 1'b0;
    tick();
    chk("drop_done",  bus.a_done,  1);
    chk("drop_rdata", bus.a_rdata, 32'hA500_0001);
    tick();
    chk("drop_idle_gnt",  bus.a_gnt,  0);
    chk("drop_idle_done", bus.a_done, 0);
    tick();
    chk("drop_no_a_gnt", bus.a_gnt, 0);
    chk("drop_no_b_gnt", bus.b_gnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
